c2sif_initiator: RTL and testbench
==================================

# c2sif_initiator

Synthesizable initiator for the c2sif four-phase request/acknowledge protocol. It takes commands from a local valid/ready port and drives req/id/fn/data toward a c2sif responder. It waits for ack, captures ret, completes the return-to-zero phase and hands the result back on a response port. It sits on the host side of the link, opposite the responder drivers on the bench, and bounds both handshake phases with a timeout.

## Interface
- ID_W, 8: width of id.
- FN_W, 8: width of fn; fn 0 = write.
- DATA_W, 32: width of data and ret.
- TIMEOUT, 1023: max cycles per handshake phase; 0 disables timeouts.
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_id  input  ID_W  target responder id.
- cmd_fn  input  FN_W  function code.
- cmd_data  input  DATA_W  payload.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
- rsp_ret  output  DATA_W  ret captured from the responder.
- rsp_err  output  2  bit0 = ack timeout, bit1 = release timeout.
- req  output  1  c2sif request.
- id, fn, data  output  ID_W/FN_W/DATA_W  c2sif request fields; held stable while req=1.
- ack  input  1  c2sif acknowledge; may be asynchronous to clk.
- ret  input  DATA_W  c2sif return value; stable while ack=1.
- busy  output  1  state != IDLE.

## Operation
- ack passes through a 2-flop synchronizer into ack_s. ret is sampled directly, only when ack_s=1.
- IDLE: cmd_ready = !ack_s. A stale ack blocks acceptance. On accept, latch cmd_* into id/fn/data, clear the timer and rsp_err, and go to REQ.
- REQ: req=1; the timer increments each cycle.
  - On ack_s=1: latch ret into rsp_ret and go to REL.
  - If TIMEOUT!=0 and the timer reaches TIMEOUT with ack_s=0: set rsp_err[0], leave rsp_ret at 0, and go to REL.
- REL: req=0; the timer restarts from 0.
  - On ack_s=0: go to DONE.
  - If TIMEOUT!=0 and the timer reaches TIMEOUT with ack_s=1: set rsp_err[1] and go to DONE.
- DONE: rsp_valid=1. rsp_ret and rsp_err hold until rsp_ready=1, then return to IDLE.
- id, fn and data keep their last values after the transaction. Only req returns to 0.
- The fn value is passed through untouched; the block does not interpret it.
- The timer width is clog2(TIMEOUT+1). The timer saturates and never wraps.
- Simultaneous events:
  - In REQ, ack_s=1 on the same cycle the timer reaches TIMEOUT: ack wins, no error.
  - In REL, the same rule applies: release wins.

## Timing
- Reset values: req=0, id=0, fn=0, data=0, rsp_valid=0, rsp_ret=0, rsp_err=0, busy=0.
- cmd_ready=0 while rst=1. Synchronizer flops and the timer clear to 0.
- Reset mid-transaction: the state returns to IDLE at the reset edge. req drops the cycle after the rst edge, and any pending response is discarded.
- Accept at edge T: req=1 with valid id/fn/data after edge T.
- Ack synchronizer latency:
  - If ack is first high at edge k, ack_s=1 after edge k+1.
  - At edge k+2, rsp_ret is latched and req=0.
- Release: if ack is first low at edge m, the FSM enters DONE at edge m+2, and rsp_valid=1 after it.
- Minimum transaction with an immediate responder: accept to rsp_valid is 6 cycles.
- Back-to-back: rsp_ready at DONE edge D returns to IDLE. The next accept can occur at D+1, giving one idle cycle with cmd_ready=1.
- Ack timeout: req stays high for exactly TIMEOUT+1 cycles (timer 0..TIMEOUT), then drops.
- Protocol guarantees: req never rises while ack_s=1, and req never falls before ack_s=1 except on timeout or reset.

## Test plan
- Write handshake: cmd id=0, fn=0, data=0xDEADBEEF. The responder acks 2 cycles after req with ret=3210. Required: rsp_ret=3210, rsp_err=0, req high during ack, req low before rsp_valid, data stable while req=1.
- Wrong id, no ack, TIMEOUT=16: req high for 17 cycles, then low. Required: rsp_err=01, rsp_ret=0, rsp_valid=1.
- Stuck ack, TIMEOUT=16: the responder never drops ack after req falls. Required: rsp_err=10 after 17 REL cycles, and cmd_ready stays 0 until ack drops.
- Back-to-back: 4 commands (data 1..4, ret=data+0x100) with rsp_ready held at 1. Required: 4 responses in order with matching ret, no req overlap, one IDLE cycle between transactions.
- Backpressure: rsp_ready=0 for 10 cycles. Required: rsp_valid, rsp_ret and rsp_err hold, cmd_ready=0, and the state advances only after rsp_ready.
- Reset mid-REQ, asserted 3 cycles after accept: req=0 after the reset edge, rsp_valid=0, and a new command completes normally afterwards.

Source files
------------

// File: rtl/c2sif_initiator.sv
// rtl/c2sif_initiator.sv - c2sif four-phase initiator with bounded handshake phases
module c2sif_initiator #(
    parameter int ID_W    = 8,
    parameter int FN_W    = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [FN_W-1:0]   cmd_fn,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_ret,
    output logic [1:0]        rsp_err,
    output logic              req,
    output logic [ID_W-1:0]   id,
    output logic [FN_W-1:0]   fn,
    output logic [DATA_W-1:0] data,
    input  logic              ack,
    input  logic [DATA_W-1:0] ret,
    output logic              busy
);

    // A zero TIMEOUT disables the phase bounds; keep a 1-bit timer so the width stays legal.
    localparam int          TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    localparam bit          TO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          ack_meta;
    logic          ack_s;
    logic [TW-1:0] timer;
    logic          accept;
    logic          cap_ret;
    logic          set_err0;
    logic          set_err1;
    logic          timer_clr;
    logic          timer_at_max;

    // Two-flop synchronizer: ack may come from a different clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= ack;
            ack_s    <= ack_meta;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign timer_at_max = TO_EN && (timer == TMAX);

    // Next-state logic; an ack/release seen on the timeout cycle takes priority over the error.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        cap_ret    = 1'b0;
        set_err0   = 1'b0;
        set_err1   = 1'b0;
        timer_clr  = 1'b0;
        case (state)
            S_IDLE: begin
                // A stale ack from the previous transaction blocks a new request.
                if (cmd_valid && !ack_s) begin
                    accept     = 1'b1;
                    timer_clr  = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_s) begin
                    cap_ret    = 1'b1;
                    timer_clr  = 1'b1;
                    state_next = S_REL;
                end else if (timer_at_max) begin
                    set_err0   = 1'b1;
                    timer_clr  = 1'b1;
                    state_next = S_REL;
                end
            end
            S_REL: begin
                if (!ack_s) begin
                    state_next = S_DONE;
                end else if (timer_at_max) begin
                    set_err1   = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Phase timer: restarts at the start of each phase and saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (timer_clr) begin
            timer <= '0;
        end else if ((state == S_REQ || state == S_REL) && timer != TMAX) begin
            timer <= timer + TW'(1);
        end
    end

    // Request fields and response holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            id      <= '0;
            fn      <= '0;
            data    <= '0;
            rsp_ret <= '0;
            rsp_err <= 2'b00;
        end else begin
            if (accept) begin
                id      <= cmd_id;
                fn      <= cmd_fn;
                data    <= cmd_data;
                rsp_ret <= '0;
                rsp_err <= 2'b00;
            end
            if (cap_ret) begin
                rsp_ret <= ret;
            end
            if (set_err0) begin
                rsp_err[0] <= 1'b1;
            end
            if (set_err1) begin
                rsp_err[1] <= 1'b1;
            end
        end
    end

    assign cmd_ready = (state == S_IDLE) && !ack_s && !rst;
    assign req       = (state == S_REQ);
    assign rsp_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_c2sif_initiator.sv
// tb/tb_c2sif_initiator.sv - directed self-checking bench for c2sif_initiator
module tb_c2sif_initiator;

    localparam int ID_W    = 8;
    localparam int FN_W    = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ID_W-1:0]   cmd_id;
    logic [FN_W-1:0]   cmd_fn;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_ret;
    logic [1:0]        rsp_err;
    logic              req;
    logic [ID_W-1:0]   id;
    logic [FN_W-1:0]   fn;
    logic [DATA_W-1:0] data;
    logic              ack;
    logic [DATA_W-1:0] ret;
    logic              busy;

    logic              auto_rsp;
    logic              ack_m;
    logic [DATA_W-1:0] ret_m;

    int checks = 0;
    int errors = 0;

    // Immediate responder in auto mode: ack follows req, ret = data + 0x100.
    assign ack = auto_rsp ? req : ack_m;
    assign ret = auto_rsp ? (data + 32'h100) : ret_m;

    c2sif_initiator #(
        .ID_W(ID_W), .FN_W(FN_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_id(cmd_id), .cmd_fn(cmd_fn), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_ret(rsp_ret), .rsp_err(rsp_err),
        .req(req), .id(id), .fn(fn), .data(data),
        .ack(ack), .ret(ret), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_accept(input logic [ID_W-1:0] i, input logic [FN_W-1:0] f,
                             input logic [DATA_W-1:0] d, output bit ok);
        ok = 1'b0;
        cmd_id = i; cmd_fn = f; cmd_data = d; cmd_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (cmd_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({cmd_ready, req, busy, rsp_valid, rsp_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready/req/busy/valid/err=%b expected 000000",
                     {cmd_ready, req, busy, rsp_valid, rsp_err});
        end
        checks++;
        if ({id, fn, data, rsp_ret} !== '0) begin
            errors++;
            $display("FAIL reset_data: got id=%h fn=%h data=%h ret=%h expected all 0", id, fn, data, rsp_ret);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        bit ok;
        auto_rsp = 1'b0; ack_m = 1'b0; ret_m = '0;
        do_accept(8'h00, 8'h00, 32'hDEADBEEF, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL write_accept: got no accept expected accept"); end
        checks++;
        if ({req, busy} !== 2'b11 || data !== 32'hDEADBEEF || id !== 8'h00 || fn !== 8'h00) begin
            errors++;
            $display("FAIL write_req_start: got req=%b busy=%b data=%h expected 1 1 deadbeef", req, busy, data);
        end
        tick(); tick();
        ack_m = 1'b1; ret_m = 32'd3210;
        checks++;
        if (req !== 1'b1) begin errors++; $display("FAIL write_req_at_ack: got %b expected 1", req); end
        tick(); tick();
        checks++;
        if (req !== 1'b1 || data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_req_hold: got req=%b data=%h expected 1 deadbeef", req, data);
        end
        tick();
        checks++;
        if (req !== 1'b0 || rsp_ret !== 32'd3210) begin
            errors++;
            $display("FAIL write_req_drop: got req=%b ret=%0d expected 0 3210", req, rsp_ret);
        end
        ack_m = 1'b0;
        tick(); tick();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL write_early_valid: got %b expected 0", rsp_valid); end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_ret !== 32'd3210 || rsp_err !== 2'b00 || req !== 1'b0) begin
            errors++;
            $display("FAIL write_rsp: got valid=%b ret=%0d err=%b req=%b expected 1 3210 00 0",
                     rsp_valid, rsp_ret, rsp_err, req);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_idle: got valid=%b busy=%b data=%h expected 0 0 deadbeef", rsp_valid, busy, data);
        end
    endtask

    task automatic test_ack_timeout();
        bit ok;
        int n;
        auto_rsp = 1'b0; ack_m = 1'b0;
        do_accept(8'h55, 8'h01, 32'h00000BAD, ok);
        n = 0;
        while (req === 1'b1 && n < 100) begin n++; tick(); end
        checks++;
        if (n != TIMEOUT + 1) begin errors++; $display("FAIL ack_to_req_len: got %0d expected %0d", n, TIMEOUT + 1); end
        wait_rsp(ok);
        checks++;
        if (!ok || rsp_err !== 2'b01 || rsp_ret !== '0) begin
            errors++;
            $display("FAIL ack_to_rsp: got valid=%b err=%b ret=%h expected 1 01 0", rsp_valid, rsp_err, rsp_ret);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_stuck_ack();
        bit ok;
        int n;
        auto_rsp = 1'b0;
        do_accept(8'h01, 8'h02, 32'h1234, ok);
        ack_m = 1'b1; ret_m = 32'hABCD;
        n = 0;
        while (req === 1'b1 && n < 50) begin n++; tick(); end
        checks++;
        if (n != 3) begin errors++; $display("FAIL stuck_req_len: got %0d expected 3", n); end
        n = 0;
        while (busy === 1'b1 && rsp_valid === 1'b0 && n < 50) begin n++; tick(); end
        checks++;
        if (n != TIMEOUT + 1) begin errors++; $display("FAIL stuck_rel_len: got %0d expected %0d", n, TIMEOUT + 1); end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 2'b10 || rsp_ret !== 32'hABCD) begin
            errors++;
            $display("FAIL stuck_rsp: got valid=%b err=%b ret=%h expected 1 10 abcd", rsp_valid, rsp_err, rsp_ret);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        cmd_id = 8'h07; cmd_fn = 8'h00; cmd_data = 32'h5; cmd_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (cmd_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL stuck_block: got ready=%b busy=%b expected 0 0", cmd_ready, busy);
            end
            tick();
        end
        ack_m = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL stuck_sync_lat: got %b expected 0", cmd_ready); end
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL stuck_unblock: got %b expected 1", cmd_ready); end
        cmd_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int nsent, nrsp, last_acc, cyc;
        bit acc;
        auto_rsp = 1'b1; rsp_ready = 1'b1;
        cmd_id = 8'h03; cmd_fn = 8'h01; cmd_data = 32'd1; cmd_valid = 1'b1;
        nsent = 0; nrsp = 0; last_acc = -1; cyc = 0;
        while (nrsp < 4 && cyc < 200) begin
            if (rsp_valid === 1'b1) begin
                checks++;
                if (rsp_ret !== 32'(nrsp + 1) + 32'h100 || rsp_err !== 2'b00 || req !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_rsp%0d: got ret=%h err=%b req=%b expected %h 00 0",
                             nrsp, rsp_ret, rsp_err, req, 32'(nrsp + 1) + 32'h100);
                end
                nrsp++;
            end
            acc = cmd_valid && cmd_ready;
            if (acc && last_acc >= 0) begin
                checks++;
                if (cyc - last_acc != 8) begin
                    errors++;
                    $display("FAIL b2b_gap: got %0d expected 8", cyc - last_acc);
                end
            end
            if (acc) last_acc = cyc;
            tick();
            cyc++;
            if (acc) begin
                nsent++;
                if (nsent < 4) cmd_data = 32'(nsent + 1);
                else cmd_valid = 1'b0;
            end
        end
        checks++;
        if (nrsp != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", nrsp); end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        auto_rsp = 1'b1; rsp_ready = 1'b0;
        do_accept(8'h02, 8'h00, 32'h77, ok);
        wait_rsp(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_wait: got no rsp_valid expected rsp_valid"); end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({rsp_valid, cmd_ready, busy} !== 3'b101 || rsp_ret !== 32'h177 || rsp_err !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold: got valid/ready/busy=%b ret=%h err=%b expected 101 177 00",
                         {rsp_valid, cmd_ready, busy}, rsp_ret, rsp_err);
            end
            tick();
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid_req();
        bit ok;
        auto_rsp = 1'b0; ack_m = 1'b0;
        do_accept(8'h09, 8'h00, 32'h99, ok);
        tick(); tick(); tick();
        checks++;
        if (req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got req=%b expected 1", req); end
        rst = 1'b1;
        tick();
        checks++;
        if ({req, rsp_valid, busy, cmd_ready} !== 4'b0 || data !== '0) begin
            errors++;
            $display("FAIL rst_mid: got req/valid/busy/ready=%b data=%h expected 0000 0",
                     {req, rsp_valid, busy, cmd_ready}, data);
        end
        rst = 1'b0;
        tick();
        auto_rsp = 1'b1;
        do_accept(8'h04, 8'h05, 32'h42, ok);
        wait_rsp(ok);
        checks++;
        if (!ok || rsp_ret !== 32'h142 || rsp_err !== 2'b00 || fn !== 8'h05) begin
            errors++;
            $display("FAIL rst_mid_after: got valid=%b ret=%h err=%b fn=%h expected 1 142 00 05",
                     rsp_valid, rsp_ret, rsp_err, fn);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_id = '0; cmd_fn = '0; cmd_data = '0;
        rsp_ready = 1'b0; auto_rsp = 1'b0; ack_m = 1'b0; ret_m = '0;
        test_reset();
        test_write();
        test_ack_timeout();
        test_stuck_ack();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
